sync_rr_arbiter: RTL and testbench

SYNC_RR_ARBITER -- requirements
Module: sync_rr_arbiter

---
 rtl/sync_rr_arbiter_if.sv | 41 ++++
 rtl/sync_rr_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sync_rr_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sync_rr_arbiter_if.sv
// ---------------------------------------------------------------------------
// sync_rr_arbiter_if
// Groups the request/grant handshake of the round-robin arbiter.
//
// Signals:
//   async_req [NUM_REQ]  per-requester request lines, asynchronous to clk
//   done                 release pulse from the current owner, synchronous
//   grant     [NUM_REQ]  one-hot registered grant, all-zero when idle
//   busy                 high while any grant bit is high
//   timeout              one-cycle pulse when a grant is revoked by the hold
//                        limit (only active with ARB_TIMEOUT_EN)
//
// Modports:
//   master  requester side (drives async_req/done)
//   slave   arbiter side   (drives grant/busy/timeout)
// ---------------------------------------------------------------------------
interface sync_rr_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] async_req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic               busy;
  logic               timeout;

  modport master (
    output async_req,
    output done,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  async_req,
    input  done,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/sync_rr_arbiter.sv
// ---------------------------------------------------------------------------
// sync_rr_arbiter
// Round-robin arbiter for NUM_REQ requesters whose request lines are
// asynchronous to clk. Every request bit is brought into the clock domain by
// a two-flop synchronizer; a three-state FSM (IDLE/GRANT/RELEASE) hands out a
// one-hot grant that is held until the owner pulses done.
//
// Parameters:
//   NUM_REQ   number of requesters (2..8)
//   HOLD_MAX  grant-hold cycle limit (2..255), used only with ARB_TIMEOUT_EN
//
// Ports:
//   clk    system clock, rising edge
//   n_rst  asynchronous active-low reset
//   bus    sync_rr_arbiter_if.slave: async_req, done in; grant, busy,
//          timeout out
//
// Optional feature macro: ARB_TIMEOUT_EN
//   When defined, a grant not released within HOLD_MAX cycles is revoked and
//   timeout pulses for one cycle. When undefined, no hold counter exists and
//   timeout is tied low.
// ---------------------------------------------------------------------------
module sync_rr_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int HOLD_MAX = 15
) (
  input logic             clk,
  input logic             n_rst,
  sync_rr_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RESET = IDX_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_param
    $error("sync_rr_arbiter: NUM_REQ or HOLD_MAX out of range");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  logic [NUM_REQ-1:0] req_meta;
  logic [NUM_REQ-1:0] req_sync;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   owner_q, owner_d;

  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  // Two-flop synchronizer per request bit; only req_sync feeds the FSM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_meta <= '0;
      req_sync <= '0;
    end else begin
      req_meta <= bus.async_req;
      req_sync <= req_meta;
    end
  end

  // Round-robin search: start one above the last owner and wrap, so the
  // previous owner has the lowest priority in the next round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % NUM_REQ);
      if (!win_found && req_sync[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic. done is only honoured in GRANT; RELEASE is a fixed
  // one-cycle gap that ignores requests.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    owner_d = owner_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    timeout_d  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          grant_d = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
          owner_d = win_idx;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        // done wins over the hold limit when both land on the same cycle.
        if (bus.done) begin
          state_d = RELEASE;
          grant_d = '0;
          last_d  = owner_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_cnt_q == HOLD_LIMIT) begin
          state_d   = RELEASE;
          grant_d   = '0;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
`endif
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register; reset drops the grant immediately with no RELEASE cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LAST_RESET;
      owner_q <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      owner_q <= owner_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
`endif
    end
  end

  assign bus.grant = grant_q;
  assign bus.busy  = |grant_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sync_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sync_rr_arbiter
// Self-checking bench for sync_rr_arbiter (NUM_REQ=4, HOLD_MAX=15).
// A table of per-cycle {async_req, done, expected grant} records drives the
// main round-robin traffic; hand-written sequences cover the glitch, long
// hold / timeout (ARB_TIMEOUT_EN) and mid-grant reset cases.
// Inputs change on the falling edge; outputs are sampled 1 time unit after
// the rising edge.
// ---------------------------------------------------------------------------
module tb_sync_rr_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int HOLD_MAX = 15;
  localparam int NUM_VEC  = 33;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
  } vec_t;

  logic clk = 1'b0;
  logic n_rst;
  int   check_count = 0;
  int   pass_count  = 0;
  vec_t vecs [NUM_VEC];

  sync_rr_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  sync_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk  (clk),
    .n_rst(n_rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Drive the requester side on the falling edge.
  task automatic applyStimulus(input logic [3:0] req, input logic done);
    @(negedge clk);
    bus.async_req = req;
    bus.done      = done;
  endtask

  // Advance to just after the next rising edge.
  task automatic stepEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Grant, busy derived from the expected grant, timeout expected low.
  task automatic checkState(input string name, input logic [3:0] exp_grant);
    checkOutput({name, "_grant"}, 32'(bus.grant), 32'(exp_grant));
    checkOutput({name, "_busy"}, 32'(bus.busy), 32'(|exp_grant));
    checkOutput({name, "_timeout"}, 32'(bus.timeout), 32'd0);
  endtask

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;
    int   held;

    // Per-cycle table: inputs applied before the edge, grant expected after.
    vecs[0]  = '{4'b0001, 1'b0, 4'b0000};
    vecs[1]  = '{4'b0001, 1'b0, 4'b0000};
    vecs[2]  = '{4'b0001, 1'b0, 4'b0001};
    vecs[3]  = '{4'b0001, 1'b0, 4'b0001};
    vecs[4]  = '{4'b0000, 1'b1, 4'b0000};
    vecs[5]  = '{4'b0000, 1'b0, 4'b0000};
    vecs[6]  = '{4'b0000, 1'b1, 4'b0000};
    vecs[7]  = '{4'b1111, 1'b0, 4'b0000};
    vecs[8]  = '{4'b1111, 1'b0, 4'b0000};
    vecs[9]  = '{4'b1111, 1'b0, 4'b0010};
    vecs[10] = '{4'b1111, 1'b1, 4'b0000};
    vecs[11] = '{4'b1111, 1'b0, 4'b0000};
    vecs[12] = '{4'b1111, 1'b0, 4'b0100};
    vecs[13] = '{4'b1111, 1'b1, 4'b0000};
    vecs[14] = '{4'b1111, 1'b0, 4'b0000};
    vecs[15] = '{4'b1111, 1'b0, 4'b1000};
    vecs[16] = '{4'b1111, 1'b1, 4'b0000};
    vecs[17] = '{4'b1111, 1'b0, 4'b0000};
    vecs[18] = '{4'b1111, 1'b0, 4'b0001};
    vecs[19] = '{4'b0111, 1'b1, 4'b0000};
    vecs[20] = '{4'b0111, 1'b0, 4'b0000};
    vecs[21] = '{4'b0111, 1'b0, 4'b0010};
    vecs[22] = '{4'b0111, 1'b1, 4'b0000};
    vecs[23] = '{4'b1100, 1'b0, 4'b0000};
    vecs[24] = '{4'b1100, 1'b0, 4'b0100};
    vecs[25] = '{4'b1000, 1'b0, 4'b0100};
    vecs[26] = '{4'b1000, 1'b0, 4'b0100};
    vecs[27] = '{4'b1000, 1'b1, 4'b0000};
    vecs[28] = '{4'b1000, 1'b0, 4'b0000};
    vecs[29] = '{4'b1000, 1'b0, 4'b1000};
    vecs[30] = '{4'b0000, 1'b1, 4'b0000};
    vecs[31] = '{4'b0000, 1'b0, 4'b0000};
    vecs[32] = '{4'b0000, 1'b0, 4'b0000};

    // Reset state.
    n_rst         = 1'b0;
    bus.async_req = '0;
    bus.done      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkState("reset", 4'b0000);
    @(negedge clk);
    n_rst = 1'b1;

    // Table-driven round-robin traffic.
    for (int i = 0; i < NUM_VEC; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      stepEdge();
      checkState($sformatf("vec%0d", i), vecs[i].exp_grant);
    end

    // Glitch between edges is never sampled; done in IDLE is ignored.
    @(posedge clk);
    #1 bus.async_req = 4'b0010;
    #3 bus.async_req = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(4'b0000, 1'(k % 2 == 0));
      stepEdge();
      checkState($sformatf("glitch%0d", k), 4'b0000);
    end
    applyStimulus(4'b0100, 1'b0);
    stepEdge();
    checkState("lat_edge1", 4'b0000);
    stepEdge();
    checkState("lat_edge2", 4'b0000);
    stepEdge();
    checkState("lat_edge3", 4'b0100);
    applyStimulus(4'b0000, 1'b1);
    stepEdge();
    checkState("lat_release", 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    stepEdge();

    // Long hold: requester 0 keeps the grant without pulsing done.
    applyStimulus(4'b0001, 1'b0);
    found = 1'b0;
    for (int c = 0; c < 6 && !found; c++) begin
      stepEdge();
      if (bus.grant == 4'b0001) found = 1'b1;
    end
    checkOutput("hold_grant_arrives", 32'(found), 32'd1);

`ifdef ARB_TIMEOUT_EN
    held = 1;
    for (int c = 0; c < 40; c++) begin
      stepEdge();
      if (bus.grant == 4'b0001) held++;
      else break;
    end
    checkOutput("timeout_hold_cycles", 32'(held), 32'(HOLD_MAX));
    checkOutput("timeout_grant_cleared", 32'(bus.grant), 32'd0);
    checkOutput("timeout_pulse", 32'(bus.timeout), 32'd1);
    stepEdge();
    checkOutput("timeout_pulse_end", 32'(bus.timeout), 32'd0);
    checkOutput("timeout_release_gap", 32'(bus.grant), 32'd0);
    stepEdge();
    checkOutput("timeout_regrant", 32'(bus.grant), 32'h1);
    held = 1;
    while (held < HOLD_MAX) begin
      stepEdge();
      checkOutput("limit_hold", 32'(bus.grant), 32'h1);
      held++;
    end
    applyStimulus(4'b0000, 1'b1);
    stepEdge();
    checkState("limit_done_release", 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    stepEdge();
    checkState("limit_idle", 4'b0000);
`else
    for (int c = 0; c < 20; c++) begin
      stepEdge();
      checkState($sformatf("hold%0d", c), 4'b0001);
    end
    applyStimulus(4'b0000, 1'b1);
    stepEdge();
    checkState("hold_release", 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    stepEdge();
`endif

    // Reset mid-grant drops grant at once; next grant goes to index 0.
    applyStimulus(4'b0010, 1'b0);
    stepEdge();
    stepEdge();
    stepEdge();
    checkState("pre_reset_grant", 4'b0010);
    @(negedge clk);
    bus.async_req = 4'b1111;
    #2 n_rst = 1'b0;
    #1;
    checkState("reset_mid_grant", 4'b0000);
    @(negedge clk);
    n_rst = 1'b1;
    stepEdge();
    checkState("post_reset_edge1", 4'b0000);
    stepEdge();
    checkState("post_reset_edge2", 4'b0000);
    stepEdge();
    checkState("post_reset_edge3", 4'b0001);
    applyStimulus(4'b0000, 1'b1);
    stepEdge();
    checkState("post_reset_release", 4'b0000);
    applyStimulus(4'b0000, 1'b0);
    stepEdge();
    checkState("post_reset_idle", 4'b0000);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
